// File: rtl/adpll_loop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : adpll_loop_ctrl
//  Description : ADPLL digital loop controller. A SAR coarse search is
//                followed by linear tracking with a selectable step of
//                1 << alpha. Alternating phase-detector decisions declare
//                lock. Once locked, the step drops to 1, and a run of
//                identical decisions drops lock again.
//                Optional TRACK timeout restart: define ADPLL_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module adpll_loop_ctrl #(
    parameter int CW         = 8,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic          clk_ref,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          pd_valid,
    input  logic          lead_lag,
    input  logic [1:0]    alpha,
    output logic [CW-1:0] lambda,
    output logic          lock,
    output logic [1:0]    state,
    output logic          retry
);

    // The arithmetic width is one bit wider than lambda. It needs at least
    // four bits so that a step of 8 is representable when CW is very small.
    localparam int c_AW     = (CW >= 3) ? CW + 1 : 4;
    localparam int c_KW     = $clog2(CW);
    localparam int c_ALT_W  = $clog2(LOCK_CNT + 1);
    localparam int c_SAME_W = $clog2(UNLOCK_CNT + 1);

    localparam logic [CW-1:0]       c_MID       = CW'(1) << (CW - 1);
    localparam logic [c_AW-1:0]     c_MAX_EXT   = {{(c_AW-CW){1'b0}}, {CW{1'b1}}};
    localparam logic [c_ALT_W-1:0]  c_LOCK_CNT  = c_ALT_W'(LOCK_CNT);
    // A run of UNLOCK_CNT identical samples contains UNLOCK_CNT-1 repeats.
    localparam logic [c_SAME_W-1:0] c_UNLOCK_M1 = c_SAME_W'(UNLOCK_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SAR    = 2'b01,
        ST_TRACK  = 2'b10,
        ST_LOCKED = 2'b11
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_lambda;
    logic                r_lock;
    logic [c_KW-1:0]     r_k;
    logic                r_prev;
    logic [c_ALT_W-1:0]  r_alt;
    logic [c_SAME_W-1:0] r_same;

    logic [CW-1:0]       w_bit;
    logic [CW-1:0]       w_sar;
    logic [c_AW-1:0]     w_ext;
    logic [c_AW-1:0]     w_step;
    logic [c_AW-1:0]     w_up;
    logic [c_AW-1:0]     w_dn;
    logic [CW-1:0]       w_track;
    logic [c_ALT_W-1:0]  w_alt_nx;
    logic [c_SAME_W-1:0] w_same_nx;
    logic                w_lock_hit;
    logic                w_unlock_hit;
    logic                w_unused_bits;

    // SAR trial: drop the bit under test on a lead decision, then set the next bit.
    assign w_bit = CW'(1) << r_k;
    assign w_sar = (lead_lag ? r_lambda : (r_lambda & ~w_bit))
                 | ((r_k != '0) ? (w_bit >> 1) : '0);

    // Tracking step. The step is 1 once locked. Results are clamped at both rails.
    assign w_ext   = {{(c_AW-CW){1'b0}}, r_lambda};
    assign w_step  = (r_state == ST_LOCKED) ? c_AW'(1) : (c_AW'(1) << alpha);
    assign w_up    = w_ext + w_step;
    assign w_dn    = w_ext - w_step;
    assign w_track = lead_lag ? ((w_up > c_MAX_EXT) ? '1 : w_up[CW-1:0])
                              : ((w_ext < w_step) ? '0 : w_dn[CW-1:0]);
    assign w_unused_bits = ^w_dn[c_AW-1:CW];

    // Alternation and repeat counters, as they would be after this sample.
    assign w_alt_nx     = (lead_lag != r_prev) ? r_alt + c_ALT_W'(1) : '0;
    assign w_same_nx    = (lead_lag == r_prev) ? r_same + c_SAME_W'(1) : '0;
    assign w_lock_hit   = (w_alt_nx == c_LOCK_CNT);
    assign w_unlock_hit = (w_same_nx >= c_UNLOCK_M1);

`ifdef ADPLL_TIMEOUT_EN
    localparam int               c_TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TIMEOUT = c_TO_W'(TIMEOUT);
    logic [c_TO_W-1:0] r_to;
    logic [c_TO_W-1:0] w_to_nx;
    logic              r_retry;
    assign w_to_nx = r_to + c_TO_W'(1);
    assign retry   = r_retry;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign retry            = 1'b0;
`endif

    assign lambda = r_lambda;
    assign lock   = r_lock;
    assign state  = r_state;

    // Loop state machine: SAR search, tracking, lock and unlock decisions.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_lambda <= c_MID;
            r_lock   <= 1'b0;
            r_k      <= '0;
            r_prev   <= 1'b0;
            r_alt    <= '0;
            r_same   <= '0;
`ifdef ADPLL_TIMEOUT_EN
            r_to     <= '0;
            r_retry  <= 1'b0;
`endif
        end else begin
`ifdef ADPLL_TIMEOUT_EN
            r_retry <= 1'b0;
`endif
            if (!enable) begin
                r_state  <= ST_IDLE;
                r_lambda <= c_MID;
                r_lock   <= 1'b0;
                r_k      <= '0;
                r_prev   <= 1'b0;
                r_alt    <= '0;
                r_same   <= '0;
`ifdef ADPLL_TIMEOUT_EN
                r_to     <= '0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state  <= ST_SAR;
                        r_k      <= c_KW'(CW - 1);
                        r_lambda <= c_MID;
                    end
                    ST_SAR: if (pd_valid) begin
                        r_lambda <= w_sar;
                        if (r_k != '0) begin
                            r_k <= r_k - c_KW'(1);
                        end else begin
                            r_state <= ST_TRACK;
                            r_prev  <= lead_lag;
                            r_alt   <= '0;
                            r_same  <= '0;
`ifdef ADPLL_TIMEOUT_EN
                            r_to    <= '0;
`endif
                        end
                    end
                    ST_TRACK: if (pd_valid) begin
                        r_lambda <= w_track;
                        r_prev   <= lead_lag;
                        if (w_lock_hit) begin
                            r_state <= ST_LOCKED;
                            r_lock  <= 1'b1;
                            r_alt   <= '0;
                            r_same  <= '0;
                        end else begin
                            r_alt <= w_alt_nx;
`ifdef ADPLL_TIMEOUT_EN
                            if (w_to_nx == c_TIMEOUT) begin
                                r_state  <= ST_SAR;
                                r_lambda <= c_MID;
                                r_k      <= c_KW'(CW - 1);
                                r_alt    <= '0;
                                r_to     <= '0;
                                r_retry  <= 1'b1;
                            end else begin
                                r_to <= w_to_nx;
                            end
`endif
                        end
                    end
                    ST_LOCKED: if (pd_valid) begin
                        r_lambda <= w_track;
                        r_prev   <= lead_lag;
                        if (w_unlock_hit) begin
                            r_state <= ST_TRACK;
                            r_lock  <= 1'b0;
                            r_alt   <= '0;
                            r_same  <= '0;
`ifdef ADPLL_TIMEOUT_EN
                            r_to    <= '0;
`endif
                        end else begin
                            r_same <= w_same_nx;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
